// File: rtl/gpu_mem_pkg.sv
// rtl/gpu_mem_pkg.sv - shared memory geometry and reader state encoding
package gpu_mem_pkg;

    localparam int MEM_ADDR_W = 13;
    localparam int MEM_DATA_W = 8;
    localparam int MEM_BYTES  = 8192;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } reader_state_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous FIFO with occupancy count, push/pop in the same cycle
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/mem_stream_reader.sv
// rtl/mem_stream_reader.sv - streams a byte run from the registered-read memory to a valid/ready consumer
module mem_stream_reader
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_length,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_ren,
    output logic [ADDR_W-1:0] o_raddr,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    reader_state_t     r_state, w_state_next;
    logic [ADDR_W-1:0] r_base, w_base_next;
    logic [ADDR_W-1:0] r_raddr, w_raddr_next;
    logic [ADDR_W:0]   r_len, w_len_next;
    logic [ADDR_W:0]   r_issued, w_issued_next;
    logic              r_ren, w_ren_next;
    logic              r_busy, w_busy_next;
    logic              r_done, w_done_next;
    logic              r_rd_pending;

    logic [CW-1:0]     w_count;
    logic [CW:0]       w_occupancy;
    logic              w_empty, w_full, w_pop, w_can_issue, w_last_accept;

    byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (r_rd_pending),
        .i_pop   (w_pop),
        .i_wdata (i_rdata),
        .o_rdata (o_data),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    assign w_pop = !w_empty && i_ready;

    // Reads on the bus or in the capture stage already own a FIFO slot.
    assign w_occupancy = {1'b0, w_count} + (CW+1)'(r_ren) + (CW+1)'(r_rd_pending);
    assign w_can_issue = (r_issued != r_len) && !w_full
                         && (w_occupancy < (CW+1)'(FIFO_DEPTH));

    // Registered o_done must rise right after the edge that pops the last byte.
    assign w_last_accept = !r_ren && !r_rd_pending
                           && ((w_count == '0) || ((w_count == CW'(1)) && w_pop));

    always_comb begin
        w_state_next  = r_state;
        w_base_next   = r_base;
        w_len_next    = r_len;
        w_issued_next = r_issued;
        w_raddr_next  = r_raddr;
        w_ren_next    = 1'b0;
        w_busy_next   = r_busy;
        w_done_next   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_base_next = i_base_addr;
                    w_len_next  = i_length;
                    if (i_length == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next  = FETCH;
                        w_busy_next   = 1'b1;
                        w_ren_next    = 1'b1;
                        w_raddr_next  = i_base_addr;
                        w_issued_next = (ADDR_W+1)'(1);
                    end
                end
            end
            FETCH: begin
                if (r_issued == r_len) begin
                    w_state_next = DRAIN;
                end else if (w_can_issue) begin
                    w_ren_next    = 1'b1;
                    w_raddr_next  = r_base + r_issued[ADDR_W-1:0];
                    w_issued_next = r_issued + (ADDR_W+1)'(1);
                end
            end
            DRAIN: begin
                if (w_last_accept) begin
                    w_state_next = IDLE;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_base       <= '0;
            r_len        <= '0;
            r_issued     <= '0;
            r_raddr      <= '0;
            r_ren        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rd_pending <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_base       <= w_base_next;
            r_len        <= w_len_next;
            r_issued     <= w_issued_next;
            r_raddr      <= w_raddr_next;
            r_ren        <= w_ren_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
            r_rd_pending <= r_ren;
        end
    end

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_ren   = r_ren;
    assign o_raddr = r_raddr;
    assign o_valid = !w_empty;

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb/tb_mem_stream_reader.sv - directed bench for mem_stream_reader against an 8K registered-read memory
module tb_mem_stream_reader;

    localparam int AW = 13;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy, done, ren, valid, ready;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata, data;

    logic [DW-1:0] mem [0:8191];

    always #5 clk = ~clk;

    mem_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_length    (length),
        .o_busy      (busy),
        .o_done      (done),
        .o_ren       (ren),
        .o_raddr     (raddr),
        .i_rdata     (rdata),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_data      (data)
    );

    always @(posedge clk) if (ren) rdata <= mem[raddr];

    int n_vec = 0;
    int n_miscmp = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [DW-1:0] got[$];
    logic [AW-1:0] addr_q[$];
    int first_valid, first_acc, last_acc, done_cyc, n_done, max_out, n_unstable, n_valid_cyc;
    logic busy_at_done;

    function automatic int n_bad(input logic [AW-1:0] b);
        int n = 0;
        foreach (got[i]) if (got[i] !== 8'(int'(b) + i)) n++;
        return n;
    endfunction

    task automatic run(input logic [AW-1:0] b, input logic [AW:0] len, input bit rnd,
                       input int restart_at, input int budget);
        int issued = 0;
        int acc = 0;
        bit prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        got.delete();
        addr_q.delete();
        first_valid = -1; first_acc = -1; last_acc = -1; done_cyc = -1;
        n_done = 0; max_out = 0; n_unstable = 0; n_valid_cyc = 0; busy_at_done = 1'bx;
        base_addr = b; length = len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (cyc == restart_at) begin
                start = 1'b1; base_addr = 13'h0555; length = 14'd3;
            end else begin
                start = 1'b0;
            end
            if (ren) begin addr_q.push_back(raddr); issued++; end
            if (issued - acc > max_out) max_out = issued - acc;
            if (prev_stall && (!valid || data !== prev_data)) n_unstable++;
            if (valid) begin
                n_valid_cyc++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy; end
            end
            if (done_cyc >= 0 && cyc > done_cyc) break;
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            prev_stall = valid && !ready;
            prev_data  = data;
            if (valid && ready) begin
                got.push_back(data);
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                acc++;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        int acc;
        for (int i = 0; i < 8192; i++) mem[i] = 8'(i);
        rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ren", ren, 0);
        check_eq("rst_raddr", raddr, 0);
        check_eq("rst_valid", valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(13'h0010, 14'd4, 1'b0, 0, 40);
        check_eq("t1_latency", first_valid, 3);
        check_eq("t1_count", got.size(), 4);
        check_eq("t1_b0", got[0], 8'h10);
        check_eq("t1_b1", got[1], 8'h11);
        check_eq("t1_b2", got[2], 8'h12);
        check_eq("t1_b3", got[3], 8'h13);
        check_eq("t1_done_cyc", done_cyc, last_acc + 1);
        check_eq("t1_done_pulses", n_done, 1);
        check_eq("t1_busy_at_done", busy_at_done, 0);

        run(13'h1FFE, 14'd4, 1'b0, 0, 40);
        check_eq("t2_nreads", addr_q.size(), 4);
        check_eq("t2_a0", addr_q[0], 13'h1FFE);
        check_eq("t2_a1", addr_q[1], 13'h1FFF);
        check_eq("t2_a2", addr_q[2], 13'h0000);
        check_eq("t2_a3", addr_q[3], 13'h0001);
        check_eq("t2_b0", got[0], 8'hFE);
        check_eq("t2_b1", got[1], 8'hFF);
        check_eq("t2_b2", got[2], 8'h00);
        check_eq("t2_b3", got[3], 8'h01);

        run(13'h0123, 14'd0, 1'b0, 0, 20);
        check_eq("t3_done_cyc", done_cyc, 1);
        check_eq("t3_done_pulses", n_done, 1);
        check_eq("t3_nreads", addr_q.size(), 0);
        check_eq("t3_valid_cycles", n_valid_cyc, 0);

        run(13'h0000, 14'd64, 1'b1, 0, 1000);
        check_eq("t4_count", got.size(), 64);
        check_eq("t4_bad_bytes", n_bad(13'h0000), 0);
        check_eq("t4_occupancy_le4", max_out <= 4, 1);
        check_eq("t4_stall_stable", n_unstable, 0);
        check_eq("t4_done_pulses", n_done, 1);
        check_eq("t4_done_cyc", done_cyc, last_acc + 1);

        run(13'h0000, 14'd8192, 1'b0, 100, 8400);
        check_eq("t5_count", got.size(), 8192);
        check_eq("t5_bad_bytes", n_bad(13'h0000), 0);
        check_eq("t5_latency", first_valid, 3);
        check_eq("t5_no_bubbles", last_acc - first_acc, 8191);
        check_eq("t5_done_pulses", n_done, 1);
        check_eq("t5_done_cyc", done_cyc, last_acc + 1);

        base_addr = 13'h0000; length = 14'd16; start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 40 && acc < 5; cyc++) begin
            if (valid && ready) acc++;
            @(posedge clk); #1;
        end
        check_eq("t6_pre_bytes", acc, 5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("t6_busy", busy, 0);
        check_eq("t6_done", done, 0);
        check_eq("t6_ren", ren, 0);
        check_eq("t6_raddr", raddr, 0);
        check_eq("t6_valid", valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(13'h0100, 14'd2, 1'b0, 0, 40);
        check_eq("t6_count", got.size(), 2);
        check_eq("t6_b0", got[0], 8'h00);
        check_eq("t6_b1", got[1], 8'h01);
        check_eq("t6_done_pulses", n_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
